fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the 16-bit program counter.
- Presents the PC address to instruction memory over a req/ack handshake and drives the PC enable so the PC advances only on accepted fetches.
- Buffers fetched instructions, with their addresses, in a 2-entry queue toward decode.
- Supports flush for taken branches and jumps.

Parameters:
- ADDR_W, 16, instruction address width (matches PC).
- DATA_W, 16, instruction word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- instAddr  in  ADDR_W  current PC value.
- pcEn  out  1  enable to PC; PC loads its next address on the edge where pcEn=1.
- imemReq  out  1  instruction-memory request.
- imemAddr  out  ADDR_W  request address.
- imemAck  in  1  memory response valid; may arrive in the same cycle as imemReq.
- imemData  in  DATA_W  instruction word, valid with imemAck.
- flush  in  1  redirect pulse from branch resolution; upstream next-PC mux selects the target while flush=1.
- instValid  out  1  buffer head valid toward decode.
- instOut  out  DATA_W  head instruction.
- instPc  out  ADDR_W  address of head instruction.
- instReady  in  1  decode accepts head this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, both buffer entries cleared, dropAddr=0.
  - All outputs are 0: pcEn, imemReq, imemAddr, instValid, instOut, instPc.
- States:
  - IDLE: imemReq=0. Next edge -> FETCH.
  - FETCH: imemReq=1, imemAddr=instAddr (combinational).
    - ack & !flush: push {imemData, instAddr}, pcEn=1.
      - Next state STALL if count after push and pop =2, else FETCH.
    - flush & ack: data discarded, no push -> FETCH.
    - flush & !ack: dropAddr<=instAddr -> DROP.
    - No ack, no flush: hold imemReq/imemAddr -> FETCH.
  - STALL: imemReq=0, buffer full.
    - Pop -> FETCH.
    - flush -> FETCH with buffer cleared.
  - DROP: imemReq=1, imemAddr=dropAddr (stale request must be completed; requests are never withdrawn).
    - On ack: data discarded, no push, no pcEn from the ack -> FETCH.
    - flush in DROP: stay in DROP, dropAddr unchanged.
- pcEn = flush | (state==FETCH & imemAck). Combinational, so the PC advances on the ack edge.
- Pop = instValid & instReady.
- instValid = (count!=0). instOut and instPc show the head entry; when count=0 they hold their last values.
- Buffer:
  - 2-entry circular queue with 1-bit read/write pointers; pointers wrap 1->0.
  - Simultaneous push and pop at count=1: count stays 1 and head advances to the new entry.
  - Push at count=2 is impossible (no request is issued in STALL).
- flush:
  - Takes priority over push and pop in the same cycle: count<=0, pointers<=0.
  - instValid=0 in the cycle after flush.
- Throughput: with zero-wait memory, one instruction per cycle. Latency from request to instValid is 1 cycle after the ack edge.
- Reset mid-transaction: the outstanding request is abandoned. Instruction memory is reset by the same signal, and any ack while reset=0 is ignored.

Test Plan:
- Reset and startup:
  - Hold reset=0 for 3 cycles -> all outputs 0.
  - Release reset with instAddr=0x0000 -> IDLE for 1 cycle, then imemReq=1 with imemAddr=0x0000.
- Zero-wait streaming:
  - Memory acks every cycle with data 0x1000+addr; PC increments by 1 on pcEn; instReady=1.
  - Required: instValid stays 1 from cycle 3 onward; instOut/instPc = 0x1000/0x0000, 0x1001/0x0001, 0x1002/0x0002, ... with no gaps. pcEn=1 every fetch cycle.
- Wait states:
  - Ack arrives 3 cycles after imemReq for addr 0x0004.
  - Required: imemReq and imemAddr=0x0004 held stable for 3 cycles; pcEn=0 until the ack cycle, then 1 for exactly one cycle; PC reads 0x0005 the next cycle.
- Backpressure:
  - instReady=0 with zero-wait memory -> after 2 pushes count=2, state STALL, imemReq=0, pcEn=0.
  - Raise instReady for 1 cycle -> one pop, FETCH resumes at the next address; head order preserved.
- Flush with outstanding request:
  - Request for 0x0008 pending with no ack; assert flush with target 0x0040.
  - Required: pcEn=1, buffer emptied, DROP entered with imemAddr held at 0x0008. The ack 2 cycles later is discarded (no instValid), then imemReq=1 with imemAddr=0x0040.
- Corner cases:
  - Flush coincident with ack and pop at count=1 -> buffer empty, ack data dropped, next fetch at the redirect target.
  - reset=0 asserted mid-DROP -> immediate return to reset values.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage sitting after the program counter.
//            Issues PC addresses to instruction memory over a req/ack
//            handshake, advances the PC only on accepted fetches (or on a
//            redirect), and buffers fetched {instruction, address} pairs in a
//            2-entry queue toward decode. A flush empties the queue; a request
//            already on the bus when the flush arrives is still completed and
//            its data thrown away.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-low reset
//            instAddr   - current PC value
//            pcEn       - PC load enable
//            imemReq    - instruction-memory request
//            imemAddr   - instruction-memory request address
//            imemAck    - memory response valid (may coincide with imemReq)
//            imemData   - instruction word, valid with imemAck
//            flush      - redirect pulse from branch resolution
//            instValid  - queue head valid toward decode
//            instOut    - head instruction
//            instPc     - address of head instruction
//            instReady  - decode accepts the head this cycle
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] instAddr,
  output logic              pcEn,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [DATA_W-1:0] imemData,
  input  logic              flush,
  output logic              instValid,
  output logic [DATA_W-1:0] instOut,
  output logic [ADDR_W-1:0] instPc,
  input  logic              instReady
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] drop_addr;

  logic [DATA_W-1:0] buf_data [2];
  logic [ADDR_W-1:0] buf_pc   [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_pc;

  logic              fetching;
  logic              push;
  logic              pop;
  logic [1:0]        count_nxt;
  logic              rd_nxt;
  logic              wr_nxt;

  assign fetching  = (state == FETCH);
  assign push      = fetching & imemAck & ~flush;
  assign instValid = (count != 2'd0);
  assign pop       = instValid & instReady;

  // Flush overrides push and pop: queue collapses to empty with pointers at 0.
  assign count_nxt = flush ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
  assign rd_nxt    = flush ? 1'b0 : (rd_ptr ^ pop);
  assign wr_nxt    = flush ? 1'b0 : (wr_ptr ^ push);

  assign imemReq  = (state == FETCH) | (state == DROP);
  assign imemAddr = (state == FETCH) ? instAddr :
                    (state == DROP)  ? drop_addr : '0;

  // Gated by reset so the PC cannot move while the block is held in reset.
  assign pcEn = reset & (flush | (fetching & imemAck));

  assign instOut = head_data;
  assign instPc  = head_pc;

  // Control FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      drop_addr <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (flush) begin
            if (!imemAck) begin
              // Request is still on the bus for the old address; keep it
              // there until memory answers.
              drop_addr <= instAddr;
              state     <= DROP;
            end else begin
              state <= FETCH;
            end
          end else if (imemAck && (count_nxt == 2'd2)) begin
            state <= STALL;
          end else begin
            state <= FETCH;
          end
        end
        STALL: begin
          if (flush || pop) state <= FETCH;
        end
        DROP: begin
          if (imemAck) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Instruction queue. The head is held in its own register so instOut and
  // instPc keep their last values once the queue drains or is flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      head_data <= '0;
      head_pc   <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      count  <= count_nxt;
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      if (push) begin
        buf_data[wr_ptr] <= imemData;
        buf_pc[wr_ptr]   <= instAddr;
      end
      if (count_nxt != 2'd0) begin
        // When the next head is the slot being written this cycle, the
        // entry comes straight from the memory bus.
        if (push && (rd_nxt == wr_ptr)) begin
          head_data <= imemData;
          head_pc   <= instAddr;
        end else begin
          head_data <= buf_data[rd_nxt];
          head_pc   <= buf_pc[rd_nxt];
        end
      end
    end
  end

endmodule
`default_nettype wire
